// File: rtl/uart_pkg.sv
// Shared UART definitions: one-hot receiver states and default oversampling ratio.
// Constants only; no latency, no backpressure.
package uart_pkg;

    localparam int N_TICKS_DEFAULT = 16;
    localparam int NB_STATE        = 4;

    // One-hot so that any multi-hot or zero pattern falls into the recovery branch.
    typedef enum logic [NB_STATE-1:0] {
        IDLE  = 4'b0001,
        START = 4'b0010,
        RECV  = 4'b0100,
        STOP  = 4'b1000
    } state_t;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchroniser for asynchronous inputs, per-bit reset value.
// Latency: 2 clocks; no backpressure.
module sync_2ff #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '1
) (
    input  logic             i_clock,
    input  logic             i_reset,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop detection, byte out with one-clock valid or frame-error strobe.
// Latency: 2-clock input sync, strobe one clock after the mid-stop sample; no backpressure, o_data held until the next good frame.
module uart_rx
    import uart_pkg::*;
#(
    parameter int NB_DATA         = 8,
    parameter int NB_STOP         = 1,
    parameter int N_TICKS         = N_TICKS_DEFAULT,
    parameter int NB_TICK_COUNTER = $clog2(NB_STOP*N_TICKS),
    parameter int NB_DATA_COUNTER = $clog2(NB_DATA)
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_tick,
    input  logic               i_rx,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    output logic               o_frame_error
);

    localparam logic [NB_TICK_COUNTER-1:0] C_TICK_ONE  = NB_TICK_COUNTER'(1);
    localparam logic [NB_TICK_COUNTER-1:0] C_TICK_MID  = NB_TICK_COUNTER'(N_TICKS/2 - 1);
    localparam logic [NB_TICK_COUNTER-1:0] C_TICK_BIT  = NB_TICK_COUNTER'(N_TICKS - 1);
    localparam logic [NB_TICK_COUNTER-1:0] C_TICK_STOP = NB_TICK_COUNTER'(NB_STOP*N_TICKS - 1);
    localparam logic [NB_DATA_COUNTER-1:0] C_BIT_ONE   = NB_DATA_COUNTER'(1);
    localparam logic [NB_DATA_COUNTER-1:0] C_BIT_LAST  = NB_DATA_COUNTER'(NB_DATA - 1);

    logic                       w_rx_s;

    state_t                     r_state;
    logic [NB_TICK_COUNTER-1:0] r_tick_cnt;
    logic [NB_DATA_COUNTER-1:0] r_bit_cnt;
    logic [NB_DATA-1:0]         r_shift;
    logic [NB_DATA-1:0]         r_data;
    logic                       r_valid;
    logic                       r_frame_error;

    state_t                     w_state_next;
    logic [NB_TICK_COUNTER-1:0] w_tick_next;
    logic [NB_DATA_COUNTER-1:0] w_bit_next;
    logic [NB_DATA-1:0]         w_shift_next;
    logic [NB_DATA-1:0]         w_data_next;
    logic                       w_valid_next;
    logic                       w_frame_error_next;

    // Idle-high line: reset the synchroniser to 1 so reset release never looks like a start bit.
    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_d     (i_rx),
        .o_q     (w_rx_s)
    );

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state       <= IDLE;
            r_tick_cnt    <= '0;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_data        <= '0;
            r_valid       <= 1'b0;
            r_frame_error <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_tick_cnt    <= w_tick_next;
            r_bit_cnt     <= w_bit_next;
            r_shift       <= w_shift_next;
            r_data        <= w_data_next;
            r_valid       <= w_valid_next;
            r_frame_error <= w_frame_error_next;
        end
    end

    always_comb begin
        w_state_next       = r_state;
        w_tick_next        = r_tick_cnt;
        w_bit_next         = r_bit_cnt;
        w_shift_next       = r_shift;
        w_data_next        = r_data;
        w_valid_next       = 1'b0;
        w_frame_error_next = 1'b0;

        case (r_state)
            IDLE: begin
                if (!w_rx_s) begin
                    w_state_next = START;
                    w_tick_next  = '0;
                end
            end

            START: begin
                if (i_tick) begin
                    if (r_tick_cnt == C_TICK_MID) begin
                        w_tick_next = '0;
                        if (!w_rx_s) begin
                            w_state_next = RECV;
                            w_bit_next   = '0;
                        end else begin
                            w_state_next = IDLE;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + C_TICK_ONE;
                    end
                end
            end

            RECV: begin
                if (i_tick) begin
                    if (r_tick_cnt == C_TICK_BIT) begin
                        w_tick_next  = '0;
                        w_shift_next = {w_rx_s, r_shift[NB_DATA-1:1]};
                        if (r_bit_cnt == C_BIT_LAST) begin
                            w_state_next = STOP;
                        end else begin
                            w_bit_next = r_bit_cnt + C_BIT_ONE;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + C_TICK_ONE;
                    end
                end
            end

            // Leaving at mid last-stop lets a back-to-back start edge be caught in IDLE.
            STOP: begin
                if (i_tick) begin
                    if (r_tick_cnt == C_TICK_STOP) begin
                        w_state_next = IDLE;
                        w_tick_next  = '0;
                        if (w_rx_s) begin
                            w_data_next  = r_shift;
                            w_valid_next = 1'b1;
                        end else begin
                            w_frame_error_next = 1'b1;
                        end
                    end else begin
                        w_tick_next = r_tick_cnt + C_TICK_ONE;
                    end
                end
            end

            default: begin
                w_state_next = IDLE;
                w_tick_next  = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    assign o_data        = r_data;
    assign o_valid       = r_valid;
    assign o_frame_error = r_frame_error;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboarded bench for uart_rx: 8N1 and 8N2 instances, directed frames driven on tick boundaries.
module tb_uart_rx;
    import uart_pkg::*;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         tick;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic       rx1;
    logic       rx2;
    logic [7:0] data1;
    logic [7:0] data2;
    logic       valid1;
    logic       valid2;
    logic       ferr1;
    logic       ferr2;

    int         n_checks = 0;
    int         n_err    = 0;
    int         tick_count = 0;
    logic [7:0] last1 = 8'h00;
    logic [7:0] last2 = 8'h00;
    exp_t       q1[$];
    exp_t       q2[$];

    uart_rx #(.NB_DATA(8), .NB_STOP(1), .N_TICKS(16)) u_dut1 (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_tick        (tick),
        .i_rx          (rx1),
        .o_data        (data1),
        .o_valid       (valid1),
        .o_frame_error (ferr1)
    );

    uart_rx #(.NB_DATA(8), .NB_STOP(2), .N_TICKS(16)) u_dut2 (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_tick        (tick),
        .i_rx          (rx2),
        .o_data        (data2),
        .o_valid       (valid2),
        .o_frame_error (ferr2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One-clock tick every 4 clocks.
    initial begin
        tick = 1'b0;
        forever begin
            repeat (3) @(posedge clk);
            #1 tick = 1'b1;
            @(posedge clk);
            #1 tick = 1'b0;
        end
    end

    always @(posedge clk) if (tick) tick_count <= tick_count + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Returns 2 time units after the n-th tick edge from now.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (!tick);
        end
        #2;
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 1) rx1 = v;
        else          rx2 = v;
    endtask

    // Must be called 2 units after a tick edge; strobe expected 8 + 128 + 16*NB_STOP ticks later.
    task automatic send_frame(input int sel, input logic [7:0] b, input bit stop_bad);
        int   ns;
        exp_t e;
        ns       = (sel == 1) ? 1 : 2;
        e.is_err = stop_bad;
        e.tick   = tick_count + 136 + 16*ns;
        if (sel == 1) begin
            if (!stop_bad) last1 = b;
            e.data = last1;
            q1.push_back(e);
        end else begin
            if (!stop_bad) last2 = b;
            e.data = last2;
            q2.push_back(e);
        end
        set_rx(sel, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_rx(sel, b[i]);
            wait_ticks(16);
        end
        if (ns == 2) begin
            set_rx(sel, 1'b1);
            wait_ticks(16);
        end
        if (stop_bad) begin
            set_rx(sel, 1'b0);
            wait_ticks(12);
            set_rx(sel, 1'b1);
            wait_ticks(20);
        end else begin
            set_rx(sel, 1'b1);
            wait_ticks(16);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (valid1 || ferr1) begin
            chk("dut1_strobe_exclusive", int'(valid1 && ferr1), 0);
            if (q1.size() == 0) begin
                chk("dut1_unexpected_strobe", 1, 0);
            end else begin
                e = q1.pop_front();
                chk("dut1_ferr", int'(ferr1), int'(e.is_err));
                chk("dut1_valid", int'(valid1), int'(!e.is_err));
                chk("dut1_data", int'(data1), int'(e.data));
                chk("dut1_tick", tick_count, e.tick);
            end
        end
        if (valid2 || ferr2) begin
            chk("dut2_strobe_exclusive", int'(valid2 && ferr2), 0);
            if (q2.size() == 0) begin
                chk("dut2_unexpected_strobe", 1, 0);
            end else begin
                e = q2.pop_front();
                chk("dut2_ferr", int'(ferr2), int'(e.is_err));
                chk("dut2_valid", int'(valid2), int'(!e.is_err));
                chk("dut2_data", int'(data2), int'(e.data));
                chk("dut2_tick", tick_count, e.tick);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c3;
        c3  = 8'hC3;
        rx1 = 1'b1;
        rx2 = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        chk("reset_data1", int'(data1), 0);
        chk("reset_valid1", int'(valid1), 0);
        chk("reset_ferr1", int'(ferr1), 0);
        chk("reset_data2", int'(data2), 0);
        chk("reset_valid2", int'(valid2), 0);
        chk("reset_ferr2", int'(ferr2), 0);
        chk("reset_state1", int'(u_dut1.r_state), int'(IDLE));
        rst = 1'b0;
        wait_ticks(4);

        // 8N2: good frame, then second stop bit low.
        send_frame(2, 8'h7E, 1'b0);
        send_frame(2, 8'h7E, 1'b1);
        wait_ticks(8);

        send_frame(1, 8'hA5, 1'b0);
        wait_ticks(8);

        send_frame(1, 8'h00, 1'b0);
        send_frame(1, 8'hFF, 1'b0);
        send_frame(1, 8'h3C, 1'b0);
        wait_ticks(8);

        // Short low pulse must be rejected as a false start.
        set_rx(1, 1'b0);
        wait_ticks(3);
        set_rx(1, 1'b1);
        wait_ticks(12);
        chk("glitch_state_idle", int'(u_dut1.r_state), int'(IDLE));
        send_frame(1, 8'h55, 1'b0);

        send_frame(1, 8'h81, 1'b1);
        wait_ticks(4);

        // Abort 0xC3 after three data bits with an asynchronous reset.
        set_rx(1, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 3; i++) begin
            set_rx(1, c3[i]);
            wait_ticks(16);
        end
        #4 rst = 1'b1;
        #1;
        chk("midframe_reset_data1", int'(data1), 0);
        chk("midframe_reset_valid1", int'(valid1), 0);
        chk("midframe_reset_ferr1", int'(ferr1), 0);
        chk("midframe_reset_state1", int'(u_dut1.r_state), int'(IDLE));
        set_rx(1, 1'b1);
        last1 = 8'h00;
        last2 = 8'h00;
        repeat (3) @(posedge clk);
        #4 rst = 1'b0;
        wait_ticks(20);

        send_frame(1, 8'h12, 1'b0);
        wait_ticks(20);

        chk("dut1_pending_expected", q1.size(), 0);
        chk("dut2_pending_expected", q2.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
